// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, 1-cycle imem latency, 1-entry skid, redirect flush
// Optional misaligned-redirect trap enabled by `define FETCH_MISALIGN_TRAP_EN
module fetch_unit #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Redirect,
    input  logic [PC_W-1:0] i_Redirect_PC,
    output logic [PC_W-3:0] o_Imem_Addr,
    input  logic [31:0]     i_Imem_Inst,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic [31:0]     o_Inst,
    output logic [PC_W-1:0] o_PC,
    output logic            o_Misalign
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_TRAP = 1'b1;

    logic [0:0]      r_State;
    logic [PC_W-1:0] r_PC;
    logic            r_InFlight;
    logic [PC_W-1:0] r_InFlightPC;
    logic            r_OutValid;
    logic [31:0]     r_OutInst;
    logic [PC_W-1:0] r_OutPC;
    logic            r_SkidValid;
    logic [31:0]     r_SkidInst;
    logic [PC_W-1:0] r_SkidPC;

    logic            w_deq;
    logic [2:0]      w_count;
    logic            w_issue;

    assign w_deq   = r_OutValid && i_Ready;
    // Entries committed after this cycle's dequeue; output + skid can hold at most two.
    assign w_count = {2'b00, r_OutValid} + {2'b00, r_SkidValid} + {2'b00, r_InFlight} - {2'b00, w_deq};
    assign w_issue = (r_State == S_RUN) && !i_Redirect && (w_count < 3'd2);

    assign o_Imem_Addr = i_Rst ? r_PC[PC_W-1:2] : RESET_PC[PC_W-1:2];
    assign o_Valid     = r_OutValid;
    assign o_Inst      = r_OutInst;
    assign o_PC        = r_OutPC;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_Misalign = (r_State == S_TRAP);
`else
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^i_Redirect_PC[1:0];
    assign o_Misalign      = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_State      <= S_RUN;
            r_PC         <= RESET_PC[PC_W-1:0];
            r_InFlight   <= 1'b0;
            r_InFlightPC <= '0;
            r_OutValid   <= 1'b0;
            r_OutInst    <= '0;
            r_OutPC      <= '0;
            r_SkidValid  <= 1'b0;
            r_SkidInst   <= '0;
            r_SkidPC     <= '0;
        end else if (i_Redirect) begin
            r_OutValid  <= 1'b0;
            r_SkidValid <= 1'b0;
            r_InFlight  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (i_Redirect_PC[1:0] != 2'b00) begin
                r_State <= S_TRAP;
            end else begin
                r_State <= S_RUN;
                r_PC    <= i_Redirect_PC;
            end
`else
            r_PC <= {i_Redirect_PC[PC_W-1:2], 2'b00};
`endif
        end else begin
            r_InFlight <= w_issue;
            if (w_issue) begin
                r_PC         <= r_PC + 4;
                r_InFlightPC <= r_PC;
            end
            // Skid drains first so program order is kept; the returning word backfills behind it.
            if (w_deq && r_SkidValid) begin
                r_OutValid <= 1'b1;
                r_OutInst  <= r_SkidInst;
                r_OutPC    <= r_SkidPC;
                if (r_InFlight) begin
                    r_SkidInst <= i_Imem_Inst;
                    r_SkidPC   <= r_InFlightPC;
                end else begin
                    r_SkidValid <= 1'b0;
                end
            end else if (w_deq || !r_OutValid) begin
                r_OutValid <= r_InFlight;
                if (r_InFlight) begin
                    r_OutInst <= i_Imem_Inst;
                    r_OutPC   <= r_InFlightPC;
                end
            end else if (r_InFlight) begin
                r_SkidValid <= 1'b1;
                r_SkidInst  <= i_Imem_Inst;
                r_SkidPC    <= r_InFlightPC;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a program-order stream model
module tb_fetch_unit;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_Redirect_PC = 32'h0;
    logic [29:0] o_Imem_Addr;
    logic [31:0] i_Imem_Inst = 32'h0;
    logic        o_Valid;
    logic        i_Ready = 1'b1;
    logic [31:0] o_Inst;
    logic [31:0] o_PC;
    logic        o_Misalign;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Redirect(i_Redirect), .i_Redirect_PC(i_Redirect_PC),
        .o_Imem_Addr(o_Imem_Addr), .i_Imem_Inst(i_Imem_Inst), .o_Valid(o_Valid), .i_Ready(i_Ready),
        .o_Inst(o_Inst), .o_PC(o_PC), .o_Misalign(o_Misalign)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [31:0] mem_word(input logic [29:0] addr);
        case (addr)
            30'd0:   return 32'h0000_0000;
            30'd1:   return 32'h0050_0513;
            30'd2:   return 32'h00a5_8633;
            default: return {2'b00, addr} * 32'h9E37_79B1 + 32'h0123_4567;
        endcase
    endfunction

    // Registered instruction memory: data for an address appears one cycle later.
    always @(posedge i_Clk) i_Imem_Inst <= mem_word(o_Imem_Addr);

    // Stream model: decode must see consecutive PCs from the last restart point, each with mem[pc].
    bit          mon_en = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_pc, hold_inst;

    always @(negedge i_Clk) begin
        if (mon_en) begin
            if (hold_pending) begin
                checks++;
                if (o_Valid !== 1'b1 || o_PC !== hold_pc || o_Inst !== hold_inst) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b pc=%h inst=%h, required valid=1 pc=%h inst=%h",
                             o_Valid, o_PC, o_Inst, hold_pc, hold_inst);
                end
            end
            hold_pending = 1'b0;
            if (!i_Rst) begin
                exp_pc = 32'h0;
            end else begin
                if (o_Valid && i_Ready) begin
                    checks++;
                    if (o_PC !== exp_pc || o_Inst !== mem_word(exp_pc[31:2])) begin
                        errors++;
                        $display("FAIL stream_order: pc=%h inst=%h, required pc=%h inst=%h",
                                 o_PC, o_Inst, exp_pc, mem_word(exp_pc[31:2]));
                    end
                    exp_pc = exp_pc + 32'd4;
                end
                if (i_Redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (i_Redirect_PC[1:0] == 2'b00) exp_pc = i_Redirect_PC;
`else
                    exp_pc = {i_Redirect_PC[31:2], 2'b00};
`endif
                end else if (o_Valid && !i_Ready) begin
                    hold_pending = 1'b1;
                    hold_pc      = o_PC;
                    hold_inst    = o_Inst;
                end
            end
        end
    end

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset();
        i_Rst = 1'b0; i_Redirect = 1'b0; i_Ready = 1'b1;
        step(); step();
        i_Rst = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] pc);
        int n = 0;
        while (!(o_Valid && o_PC == pc) && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL run_to_timeout: pc=%h valid=%b, required pc=%h valid=1", o_PC, o_Valid, pc);
        end
    endtask

    task automatic test_reset();
        i_Rst = 1'b0; i_Ready = 1'b1;
        step(); step(); step();
        checks++;
        if (o_Valid !== 1'b0 || o_Inst !== 32'h0 || o_PC !== 32'h0 || o_Misalign !== 1'b0 || o_Imem_Addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b inst=%h pc=%h mis=%b addr=%h, required all 0",
                     o_Valid, o_Inst, o_PC, o_Misalign, o_Imem_Addr);
        end
        mon_en = 1'b1;
        i_Rst = 1'b1;
        step();
        checks++;
        if (o_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_r1: valid=%b, required 0", o_Valid);
        end
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h0 || o_Inst !== 32'h0) begin
            errors++;
            $display("FAIL first_fetch: valid=%b pc=%h inst=%h, required 1/00000000/00000000", o_Valid, o_PC, o_Inst);
        end
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h4 || o_Inst !== 32'h0050_0513) begin
            errors++;
            $display("FAIL seq_fetch_1: valid=%b pc=%h inst=%h, required 1/00000004/00500513", o_Valid, o_PC, o_Inst);
        end
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h8 || o_Inst !== 32'h00a5_8633) begin
            errors++;
            $display("FAIL seq_fetch_2: valid=%b pc=%h inst=%h, required 1/00000008/00a58633", o_Valid, o_PC, o_Inst);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_to(32'h4);
        i_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_Valid !== 1'b1 || o_PC !== 32'h4 || o_Inst !== 32'h0050_0513) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b pc=%h inst=%h, required 1/00000004/00500513", i, o_Valid, o_PC, o_Inst);
            end
            if (i >= 2) begin
                checks++;
                if (o_Imem_Addr !== 30'h3) begin
                    errors++;
                    $display("FAIL bp_pc_stop[%0d]: addr=%h, required 00000003", i, o_Imem_Addr);
                end
            end
            step();
        end
        i_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_Valid !== 1'b1 || o_PC !== 32'h4 + 32'(i) * 32'd4) begin
                errors++;
                $display("FAIL bp_release[%0d]: valid=%b pc=%h, required 1/%h", i, o_Valid, o_PC, 32'h4 + 32'(i) * 32'd4);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run_to(32'h8);
        i_Redirect = 1'b1; i_Redirect_PC = 32'h4C;
        step();
        i_Redirect = 1'b0;
        checks++;
        if (o_Imem_Addr !== 30'h13 || o_Valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_n1: addr=%h valid=%b, required 00000013/0", o_Imem_Addr, o_Valid);
        end
        step();
        checks++;
        if (o_Valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_n2: valid=%b, required 0", o_Valid);
        end
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h4C || o_Inst !== mem_word(30'h13)) begin
            errors++;
            $display("FAIL redir_n3: valid=%b pc=%h inst=%h, required 1/0000004c/%h", o_Valid, o_PC, o_Inst, mem_word(30'h13));
        end
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h50) begin
            errors++;
            $display("FAIL redir_next: valid=%b pc=%h, required 1/00000050", o_Valid, o_PC);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        run_to(32'h4);
        i_Ready = 1'b0;
        step(); step(); step();
        i_Ready = 1'b1; i_Redirect = 1'b1; i_Redirect_PC = 32'h100;
        step();
        i_Redirect = 1'b0;
        step(); step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h100) begin
            errors++;
            $display("FAIL redir_stall: valid=%b pc=%h, required 1/00000100", o_Valid, o_PC);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(32'h10);
        i_Rst = 1'b0;
        step();
        checks++;
        if (o_Valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid: valid=%b, required 0", o_Valid);
        end
        i_Rst = 1'b1;
        step(); step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_restart: valid=%b pc=%h, required 1/00000000", o_Valid, o_PC);
        end
    endtask

    task automatic test_back_to_back();
        i_Ready = 1'b1;
        i_Redirect = 1'b1; i_Redirect_PC = 32'h800;
        step();
        i_Redirect_PC = 32'hFFFF_FFF0;
        step();
        i_Redirect = 1'b0;
        step(); step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_Valid !== 1'b1 || o_PC !== 32'hFFFF_FFF0 + 32'(i) * 32'd4) begin
                errors++;
                $display("FAIL b2b_wrap[%0d]: valid=%b pc=%h, required 1/%h", i, o_Valid, o_PC, 32'hFFFF_FFF0 + 32'(i) * 32'd4);
            end
            step();
        end
    endtask

    task automatic test_misalign();
        i_Ready = 1'b1;
        i_Redirect = 1'b1; i_Redirect_PC = 32'h22;
        step();
        i_Redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_Misalign !== 1'b1 || o_Valid !== 1'b0) begin
                errors++;
                $display("FAIL trap_hold[%0d]: mis=%b valid=%b, required 1/0", i, o_Misalign, o_Valid);
            end
            step();
        end
        i_Redirect = 1'b1; i_Redirect_PC = 32'h24;
        step();
        i_Redirect = 1'b0;
        checks++;
        if (o_Misalign !== 1'b0) begin
            errors++;
            $display("FAIL trap_exit: mis=%b, required 0", o_Misalign);
        end
        step(); step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h24) begin
            errors++;
            $display("FAIL trap_resume: valid=%b pc=%h, required 1/00000024", o_Valid, o_PC);
        end
`else
        step(); step();
        checks++;
        if (o_Valid !== 1'b1 || o_PC !== 32'h20 || o_Misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_ignored: valid=%b pc=%h mis=%b, required 1/00000020/0", o_Valid, o_PC, o_Misalign);
        end
`endif
    endtask

    task automatic test_random();
        int moved = 0;
        for (int i = 0; i < 2000; i++) begin
            i_Ready    = ($urandom_range(3) != 0);
            i_Redirect = ($urandom_range(24) == 0);
            if ($urandom_range(3) == 0) i_Redirect_PC = 32'hFFFF_FFF8;
            else                        i_Redirect_PC = $urandom & 32'hFFFF_FFFC;
            if (o_Valid && i_Ready) moved++;
            step();
        end
        i_Ready = 1'b1; i_Redirect = 1'b0;
        step(); step(); step();
        checks++;
        if (moved < 500) begin
            errors++;
            $display("FAIL random_progress: transfers=%0d, required >= 500", moved);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_stall();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
